// File: rtl/mm_bp_stats_regs.sv
// Branch-prediction statistics block on the CPU external bus.
// Counts branch, BTB-hit and misprediction pulses and exposes them as
// LO/HI register pairs. A LO read snapshots the upper counter bits so the
// following HI read forms a coherent pair. Also holds CTRL, STATUS and LED.
module mm_bp_stats_regs #(
  parameter logic [15:0] BASE_ADDR = 16'hC000,
  parameter int          CNT_W     = 32,
  parameter int          LED_W     = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      addr,
  input  logic [15:0]      wdata,
  input  logic             mm_we,
  input  logic             mm_re,
  output logic [15:0]      rdata,
  input  logic             inc_br_cnt,
  input  logic             inc_hit_cnt,
  input  logic             inc_mispr_cnt,
  output logic [LED_W-1:0] led
);

  localparam int SNAP_W = CNT_W - 16;

  logic              sel;
  logic [3:0]        offset;
  logic              wr_en;
  logic              rd_en;
  logic              clr;
  logic              en;
  logic [2:0]        status;
  logic [2:0]        inc;
  logic [2:0]        wrap;
  logic [2:0]        w1c;
  logic [CNT_W-1:0]  br_cnt;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  mispr_cnt;
  logic [CNT_W-1:0]  br_next;
  logic [CNT_W-1:0]  hit_next;
  logic [CNT_W-1:0]  mispr_next;
  logic [SNAP_W-1:0] br_snap;
  logic [SNAP_W-1:0] hit_snap;
  logic [SNAP_W-1:0] mispr_snap;
  logic [15:0]       br_hi;
  logic [15:0]       hit_hi;
  logic [15:0]       mispr_hi;
  logic [15:0]       led_rd;
  logic              unused_wdata;

  assign sel          = (addr[15:4] == BASE_ADDR[15:4]);
  assign offset       = addr[3:0];
  assign wr_en        = mm_we && sel;
  assign rd_en        = mm_re && sel;
  assign clr          = wr_en && (offset == 4'd0) && wdata[1];
  assign inc          = {inc_mispr_cnt, inc_hit_cnt, inc_br_cnt} & {3{en}};
  assign w1c          = (wr_en && (offset == 4'd1)) ? wdata[2:0] : 3'b000;
  assign led          = led_rd[LED_W-1:0];
  assign unused_wdata = ^wdata;

  // Next counter values and wrap detection; a clear discards any increment
  always_comb begin
    br_next    = br_cnt + CNT_W'(inc[0]);
    hit_next   = hit_cnt + CNT_W'(inc[1]);
    mispr_next = mispr_cnt + CNT_W'(inc[2]);
    wrap[0]    = inc[0] && (&br_cnt);
    wrap[1]    = inc[1] && (&hit_cnt);
    wrap[2]    = inc[2] && (&mispr_cnt);
    if (clr) begin
      br_next    = '0;
      hit_next   = '0;
      mispr_next = '0;
      wrap       = 3'b000;
    end
  end

  // Event counters, updated every cycle from their next values
  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt    <= '0;
      hit_cnt   <= '0;
      mispr_cnt <= '0;
    end else begin
      br_cnt    <= br_next;
      hit_cnt   <= hit_next;
      mispr_cnt <= mispr_next;
    end
  end

  // Upper-half snapshots captured from the pre-increment count on a LO read
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      br_snap    <= '0;
      hit_snap   <= '0;
      mispr_snap <= '0;
    end else if (rd_en) begin
      if (offset == 4'd2) br_snap    <= br_cnt[CNT_W-1:16];
      if (offset == 4'd4) hit_snap   <= hit_cnt[CNT_W-1:16];
      if (offset == 4'd6) mispr_snap <= mispr_cnt[CNT_W-1:16];
    end
  end

  // Control enable, sticky overflow flags (set beats clear) and LED register
  always_ff @(posedge clk) begin
    if (rst) begin
      en     <= 1'b1;
      status <= 3'b000;
      led_rd <= '0;
    end else begin
      if (wr_en && (offset == 4'd0)) en <= wdata[0];
      status <= wrap | (status & ~w1c);
      if (wr_en && (offset == 4'd8)) led_rd[LED_W-1:0] <= wdata[LED_W-1:0];
    end
  end

  // Zero-extended views of the snapshots for the HI registers
  always_comb begin
    br_hi                 = '0;
    hit_hi                = '0;
    mispr_hi              = '0;
    br_hi[SNAP_W-1:0]     = br_snap;
    hit_hi[SNAP_W-1:0]    = hit_snap;
    mispr_hi[SNAP_W-1:0]  = mispr_snap;
  end

  // Zero-latency read mux; idle or unselected cycles return zero
  always_comb begin
    rdata = 16'h0000;
    if (rd_en) begin
      case (offset)
        4'd0:    rdata = {15'd0, en};
        4'd1:    rdata = {13'd0, status};
        4'd2:    rdata = br_cnt[15:0];
        4'd3:    rdata = br_hi;
        4'd4:    rdata = hit_cnt[15:0];
        4'd5:    rdata = hit_hi;
        4'd6:    rdata = mispr_cnt[15:0];
        4'd7:    rdata = mispr_hi;
        4'd8:    rdata = led_rd;
        default: rdata = 16'h0000;
      endcase
    end
  end

endmodule
